// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner
// ----------------------------------------------------------------------------
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// One digit is driven per refresh slot (2**DIV_WIDTH clocks). Each digit is
// decoded as hex or BCD. The driver also supports:
//   - a per-digit enable
//   - decimal points
//   - leading-zero blanking
//   - 16-level PWM brightness
//
// All display-affecting inputs are snapshotted into shadow registers once per
// frame. A frame is one full scan of all digits. Because of the snapshot, a
// digit never changes half-way through its scan.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits_in   packed nibbles, digit i = digits_in[4i+3:4i]
//   dp_in       decimal-point request per digit (1 = lit)
//   digit_en    per-digit enable (0 = digit dark)
//   lz_blank    1 = suppress leading zeros
//   hex_mode    1 = hex decode, 0 = BCD decode (10..15 shown as a dash)
//   brightness  PWM duty, 0 = off, 15 = full on
//   seg_an      anodes, active-low, at most one low at a time
//   seg_cat     cathodes {a,b,c,d,e,f,g}, active-low
//   seg_dp      decimal-point cathode, active-low
//   frame_done  one-cycle pulse when the shadow snapshot is taken
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    hex_mode,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic [6:0]              seg_cat,
    output logic                    seg_dp,
    output logic                    frame_done
);

    // A one-digit display still needs a 1-bit index register.
    localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]        CAT_OFF  = 7'h7F;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_WIDTH-1:0]    div_cnt_q,   div_cnt_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;

    // Shadow copies of the inputs, reloaded only at frame boundaries.
    logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q,     dp_sh_d;
    logic [NUM_DIGITS-1:0]   en_sh_q,     en_sh_d;
    logic                    lz_sh_q,     lz_sh_d;
    logic                    hex_sh_q,    hex_sh_d;
    logic [3:0]              bright_sh_q, bright_sh_d;

    // Registered pin drivers.
    logic [NUM_DIGITS-1:0]   seg_an_q,     seg_an_d;
    logic [6:0]              seg_cat_q,    seg_cat_d;
    logic                    seg_dp_q,     seg_dp_d;
    logic                    frame_done_q, frame_done_d;

    logic tick;
    logic frame_edge;

    // ------------------------------------------------------------------------
    // Digit decode, active-low {a,b,c,d,e,f,g}.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] decode_nibble(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        seg = 7'b1111110;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = hex ? 7'b0001000 : 7'b1111110;
            4'hB: seg = hex ? 7'b1100000 : 7'b1111110;
            4'hC: seg = hex ? 7'b0110001 : 7'b1111110;
            4'hD: seg = hex ? 7'b1000010 : 7'b1111110;
            4'hE: seg = hex ? 7'b0110000 : 7'b1111110;
            default: seg = hex ? 7'b0111000 : 7'b1111110;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------------
    always_comb begin
        tick       = &div_cnt_q;
        frame_edge = tick && (idx_q == LAST_IDX);
        div_cnt_d  = div_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick) begin
            // With a single digit LAST_IDX is 0, so the index never moves.
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame snapshot
    // ------------------------------------------------------------------------
    always_comb begin
        digits_sh_d  = digits_sh_q;
        dp_sh_d      = dp_sh_q;
        en_sh_d      = en_sh_q;
        lz_sh_d      = lz_sh_q;
        hex_sh_d     = hex_sh_q;
        bright_sh_d  = bright_sh_q;
        frame_done_d = frame_edge;
        if (frame_edge) begin
            digits_sh_d = digits_in;
            dp_sh_d     = dp_in;
            en_sh_d     = digit_en;
            lz_sh_d     = lz_blank;
            hex_sh_d    = hex_mode;
            bright_sh_d = brightness;
        end
    end

    // ------------------------------------------------------------------------
    // Per-digit views of the shadow nibbles
    // ------------------------------------------------------------------------
    logic [3:0]            nib_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nib_zero;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib_sh[gi]   = digits_sh_q[4*gi +: 4];
        assign nib_zero[gi] = (digits_sh_q[4*gi +: 4] == 4'h0);
    end

    // Leading-zero blanking. Walk down from the most significant digit.
    // While every nibble seen so far is zero, that digit is blanked.
    // Digit 0 always shows, so a value of zero still displays "0".
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & nib_zero[i];
            lz_mask[i] = lz_sh_q & zero_run;
        end
    end

    // ------------------------------------------------------------------------
    // Select the current digit and compute the next pin values.
    // Outputs come from registered state only. This keeps a fixed one-clock
    // lag behind the counters and avoids any combinational path from the
    // input pins to the output pins.
    // ------------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic       cur_en;
    logic       cur_dp;
    logic       cur_blank;
    logic       pwm_on;
    logic       lit;

    always_comb begin
        cur_nib   = 4'h0;
        cur_en    = 1'b0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = nib_sh[i];
                cur_en    = en_sh_q[i];
                cur_dp    = dp_sh_q[i];
                cur_blank = lz_mask[i];
            end
        end

        // The top four prescaler bits act as the PWM phase within a slot.
        pwm_on = (bright_sh_q == 4'hF) ||
                 (div_cnt_q[DIV_WIDTH-1 -: 4] < bright_sh_q);
        lit    = cur_en && !cur_blank && pwm_on;

        seg_an_d  = '1;
        seg_cat_d = CAT_OFF;
        seg_dp_d  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_an_d[i] = !(lit && (idx_q == IDX_W'(i)));
        end
        if (lit) begin
            seg_cat_d = decode_nibble(cur_nib, hex_sh_q);
            seg_dp_d  = !cur_dp;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            digits_sh_q  <= '0;
            dp_sh_q      <= '0;
            en_sh_q      <= '0;
            lz_sh_q      <= 1'b0;
            hex_sh_q     <= 1'b0;
            bright_sh_q  <= 4'h0;
            seg_an_q     <= '1;
            seg_cat_q    <= CAT_OFF;
            seg_dp_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            digits_sh_q  <= digits_sh_d;
            dp_sh_q      <= dp_sh_d;
            en_sh_q      <= en_sh_d;
            lz_sh_q      <= lz_sh_d;
            hex_sh_q     <= hex_sh_d;
            bright_sh_q  <= bright_sh_d;
            seg_an_q     <= seg_an_d;
            seg_cat_q    <= seg_cat_d;
            seg_dp_q     <= seg_dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_an     = seg_an_q;
    assign seg_cat    = seg_cat_q;
    assign seg_dp     = seg_dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with NUM_DIGITS=4 and DIV_WIDTH=4.
// That gives a 16-cycle slot and a 64-cycle frame.
// Outputs are sampled on the falling edge. Sample j of a captured frame shows
// the state of slot j/16 at phase j%16.
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int DW = 4;

    // Active-low cathode patterns {a..g}.
    localparam logic [6:0] C0   = 7'b0000001;
    localparam logic [6:0] C1   = 7'b1001111;
    localparam logic [6:0] C2   = 7'b0010010;
    localparam logic [6:0] C3   = 7'b0000110;
    localparam logic [6:0] C4   = 7'b1001100;
    localparam logic [6:0] C5   = 7'b0100100;
    localparam logic [6:0] C6   = 7'b0100000;
    localparam logic [6:0] C7   = 7'b0001111;
    localparam logic [6:0] C8   = 7'b0000000;
    localparam logic [6:0] CA   = 7'b0001000;
    localparam logic [6:0] CDSH = 7'b1111110;
    localparam logic [6:0] COFF = 7'h7F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    digit_en = '0;
    logic          lz_blank = 1'b0;
    logic          hex_mode = 1'b0;
    logic [3:0]    brightness = '0;
    logic [3:0]    seg_an;
    logic [6:0]    seg_cat;
    logic          seg_dp;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] cap_an  [64];
    logic [6:0] cap_cat [64];
    logic       cap_dp  [64];
    logic       cap_fd  [64];

    seven_seg_scanner #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .hex_mode   (hex_mode),
        .brightness (brightness),
        .seg_an     (seg_an),
        .seg_cat    (seg_cat),
        .seg_dp     (seg_dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge at which frame_done is high.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_frame_seen"}, 32'(seen), 32'd1);
    endtask

    // Record one frame of output samples.
    // When mid_at >= 0, digits_in is changed to mid_digits after that sample.
    task automatic capture(input int mid_at, input logic [15:0] mid_digits);
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            cap_an[j]  = seg_an;
            cap_cat[j] = seg_cat;
            cap_dp[j]  = seg_dp;
            cap_fd[j]  = frame_done;
            if (j == mid_at) digits_in = mid_digits;
        end
    endtask

    // Compare a captured frame against hand-supplied per-slot expectations.
    // cats holds {slot3, slot2, slot1, slot0}.
    // A slot is lit for phases 0..bright-1, or for all 16 phases when bright is 15.
    task automatic verify_frame(input string tag, input logic [3:0] bright,
                                input logic [3:0] slot_lit, input logic [27:0] cats,
                                input logic [3:0] dpv);
        int fd_cnt;
        int fd_at;
        fd_cnt = 0;
        fd_at  = -1;
        for (int s = 0; s < 4; s++) begin
            int bad;
            int lit_cnt;
            int exp_lit;
            logic [6:0] ecat_s;
            bad     = 0;
            lit_cnt = 0;
            ecat_s  = cats[7*s +: 7];
            exp_lit = slot_lit[s] ? ((bright == 4'hF) ? 16 : int'(bright)) : 0;
            for (int p = 0; p < 16; p++) begin
                int j;
                bit el;
                logic [3:0] ean;
                logic [6:0] ecat;
                logic edp;
                j    = s * 16 + p;
                el   = slot_lit[s] && ((bright == 4'hF) || (p < int'(bright)));
                ean  = 4'b0001 << s;
                ean  = el ? ~ean : 4'hF;
                ecat = el ? ecat_s : COFF;
                edp  = el ? ~dpv[s] : 1'b1;
                if (cap_an[j] !== ean || cap_cat[j] !== ecat || cap_dp[j] !== edp) bad++;
                if (cap_an[j] !== 4'hF) lit_cnt++;
            end
            check($sformatf("%s_slot%0d_lit_cycles", tag, s), 32'(lit_cnt), 32'(exp_lit));
            check($sformatf("%s_slot%0d_bad_samples", tag, s), 32'(bad), 32'd0);
            if (exp_lit > 0) begin
                check($sformatf("%s_slot%0d_cat", tag, s), 32'(cap_cat[s*16]), 32'(ecat_s));
            end
        end
        for (int j = 0; j < 64; j++) begin
            if (cap_fd[j]) begin
                fd_cnt++;
                fd_at = j;
            end
        end
        check({tag, "_fd_count"}, 32'(fd_cnt), 32'd1);
        check({tag, "_fd_pos"}, 32'(fd_at), 32'd63);
    endtask

    // Release reset at a falling edge. The display must stay dark for one
    // full frame. frame_done must be seen exactly once, at sample 64: the
    // boundary tick occurs in cycle 63.
    task automatic reset_release(input string tag);
        int dark_bad;
        int fd_cnt;
        int fd_at;
        dark_bad = 0;
        fd_cnt   = 0;
        fd_at    = -1;
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (seg_an !== 4'hF || seg_cat !== COFF || seg_dp !== 1'b1) dark_bad++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = k;
            end
        end
        check({tag, "_dark_first_frame"}, 32'(dark_bad), 32'd0);
        check({tag, "_fd_count"}, 32'(fd_cnt), 32'd1);
        check({tag, "_fd_cycle"}, 32'(fd_at), 32'd64);
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] en, input logic [3:0] br,
                              input logic lz, input logic hx, input logic [3:0] dp);
        digits_in  = d;
        digit_en   = en;
        brightness = br;
        lz_blank   = lz;
        hex_mode   = hx;
        dp_in      = dp;
    endtask

    initial begin
        // 1. Reset state and dark first frame.
        set_inputs(16'h1234, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
        repeat (3) @(negedge clk);
        check("rst_an", 32'(seg_an), 32'hF);
        check("rst_cat", 32'(seg_cat), 32'(COFF));
        check("rst_dp", 32'(seg_dp), 32'd1);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset_release("por");

        // 2. Plain BCD scan of 1234 (already snapshotted at the first boundary).
        capture(-1, 16'h0);
        verify_frame("t2_1234", 4'hF, 4'hF, {C1, C2, C3, C4}, 4'h0);

        // 3. Leading-zero blanking on 0040, then blanking disabled.
        set_inputs(16'h0040, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
        wait_frame("t3a");
        capture(-1, 16'h0);
        verify_frame("t3_lz_on", 4'hF, 4'b0011, {COFF, COFF, C4, C0}, 4'h0);
        set_inputs(16'h0040, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
        wait_frame("t3b");
        capture(-1, 16'h0);
        verify_frame("t3_lz_off", 4'hF, 4'hF, {C0, C0, C4, C0}, 4'h0);

        // 4. Nibble A in BCD (dash) and hex, plus a decimal point on digit 0.
        set_inputs(16'h000A, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
        wait_frame("t4a");
        capture(-1, 16'h0);
        verify_frame("t4_bcd_A", 4'hF, 4'hF, {C0, C0, C0, CDSH}, 4'h0);
        set_inputs(16'h000A, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001);
        wait_frame("t4b");
        capture(-1, 16'h0);
        verify_frame("t4_hex_A_dp", 4'hF, 4'hF, {C0, C0, C0, CA}, 4'b0001);

        // 5. PWM duty, zero brightness, partial enable.
        set_inputs(16'h1234, 4'hF, 4'h4, 1'b0, 1'b0, 4'h0);
        wait_frame("t5a");
        capture(-1, 16'h0);
        verify_frame("t5_bright4", 4'h4, 4'hF, {C1, C2, C3, C4}, 4'h0);
        set_inputs(16'h1234, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
        wait_frame("t5b");
        capture(-1, 16'h0);
        verify_frame("t5_bright0", 4'h0, 4'hF, {C1, C2, C3, C4}, 4'h0);
        set_inputs(16'h1234, 4'b0101, 4'hF, 1'b0, 1'b0, 4'h0);
        wait_frame("t5c");
        capture(-1, 16'h0);
        verify_frame("t5_en0101", 4'hF, 4'b0101, {C1, C2, C3, C4}, 4'h0);

        // 6. Mid-frame input change must not show until the next frame.
        set_inputs(16'h1234, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
        wait_frame("t6");
        capture(20, 16'h5678);
        verify_frame("t6_old", 4'hF, 4'hF, {C1, C2, C3, C4}, 4'h0);
        capture(-1, 16'h0);
        verify_frame("t6_new", 4'hF, 4'hF, {C5, C6, C7, C8}, 4'h0);

        // Asynchronous reset in the middle of a lit slot.
        repeat (20) @(negedge clk);
        check("mid_an_before", 32'(seg_an), 32'hD);
        check("mid_cat_before", 32'(seg_cat), 32'(C7));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_an", 32'(seg_an), 32'hF);
        check("mid_rst_cat", 32'(seg_cat), 32'(COFF));
        check("mid_rst_dp", 32'(seg_dp), 32'd1);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_release("rerel");
        capture(-1, 16'h0);
        verify_frame("after_rerel", 4'hF, 4'hF, {C5, C6, C7, C8}, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
